monitor_relojes: RTL and testbench

- Single-clock checker that sits downstream of the three-stage clock divider chain (4f, 2f, f outputs).
- Samples the three divided clocks as data in the source clock domain and measures each period in source-clock cycles.
- Declares lock once the chain is stable, then flags any later period deviation or stuck clock.
- Used in benches and on-chip as a health flag for the clock tree feeding the data-path stages.

---
 rtl/monitor_relojes.sv | 140 ++++++++++++++
 tb/tb_monitor_relojes.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_relojes.sv
// Clock-tree health monitor: measures the 4f/2f/f divided-clock periods in clk_in cycles,
// locks after LOCK_N good f periods, then flags deviations/stuck clocks (3-cycle sync lag).
module monitor_relojes #(
  parameter int PER_4F = 6,
  parameter int TOL    = 1,
  parameter int LOCK_N = 4,
  parameter int CW     = 16
) (
  input  logic          clk_in,
  input  logic          reset_L,
  input  logic          clk_4f_s,
  input  logic          clk_2f_s,
  input  logic          clk_f_s,
  input  logic          clr,
  output logic          locked,
  output logic          fault,
  output logic [2:0]    err_vec,
  output logic [CW-1:0] period_f
);

  localparam int GW = $clog2(LOCK_N + 1);

  typedef enum logic [1:0] {S_INIT, S_ACQ, S_LOCK, S_FAULT} state_t;

  // Channel index follows err_vec: 2 = 4f, 1 = 2f, 0 = f
  logic [2:0]         w_in;
  logic [2:0]         r_sync1, r_sync2, r_sync3;
  logic [2:0]         r_seen;
  logic [2:0][CW-1:0] r_cnt;
  logic [2:0][CW-1:0] w_exp;
  logic [2:0][CW-1:0] w_diff;
  logic [2:0]         w_pulse, w_ok, w_bad;
  logic               w_good_f;
  state_t             r_state, w_state_nxt;
  logic [GW-1:0]      r_good_cnt, w_good_nxt;
  logic [2:0]         r_err, w_err_nxt;

  assign w_in     = {clk_4f_s, clk_2f_s, clk_f_s};
  assign w_exp[0] = CW'(4 * PER_4F);
  assign w_exp[1] = CW'(2 * PER_4F);
  assign w_exp[2] = CW'(PER_4F);
  assign w_pulse  = r_sync2 & ~r_sync3;

  // Timeout fires only on the single cycle cnt equals limit+1, so once per gap
  always_comb begin
    w_diff = '0;
    w_ok   = '0;
    w_bad  = '0;
    for (int c = 0; c < 3; c++) begin
      w_diff[c] = (r_cnt[c] >= w_exp[c]) ? (r_cnt[c] - w_exp[c]) : (w_exp[c] - r_cnt[c]);
      w_ok[c]   = (w_diff[c] <= CW'(TOL));
      w_bad[c]  = r_seen[c] & (w_pulse[c] ? ~w_ok[c]
                                          : (r_cnt[c] == w_exp[c] + CW'(TOL + 1)));
    end
  end

  assign w_good_f = w_pulse[0] & r_seen[0] & w_ok[0];

  always_ff @(posedge clk_in or negedge reset_L) begin
    if (!reset_L) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sync3  <= '0;
      r_seen   <= '0;
      r_cnt    <= '0;
      period_f <= '0;
    end else begin
      r_sync1 <= w_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (w_pulse[0]) period_f <= r_cnt[0];
      for (int c = 0; c < 3; c++) begin
        if (clr) begin
          r_cnt[c]  <= '0;
          r_seen[c] <= 1'b0;
        end else if (w_pulse[c]) begin
          r_cnt[c]  <= CW'(1);
          r_seen[c] <= 1'b1;
        end else if (r_cnt[c] != {CW{1'b1}}) begin
          r_cnt[c] <= r_cnt[c] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_err_nxt   = r_err;
    if (clr) begin
      w_state_nxt = S_INIT;
      w_good_nxt  = '0;
      w_err_nxt   = '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (&r_seen) begin
            w_state_nxt = S_ACQ;
            w_good_nxt  = '0;
          end
        end
        S_ACQ: begin
          if (|w_bad) begin
            w_good_nxt = '0;
          end else if (w_good_f) begin
            w_good_nxt = r_good_cnt + 1'b1;
            if (w_good_nxt == GW'(LOCK_N)) w_state_nxt = S_LOCK;
          end
        end
        S_LOCK: begin
          if (|w_bad) begin
            w_state_nxt = S_FAULT;
            w_err_nxt   = r_err | w_bad;
          end
        end
        S_FAULT: w_err_nxt = r_err | w_bad;
        default: w_state_nxt = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= S_INIT;
      r_good_cnt <= '0;
      r_err      <= '0;
      locked     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_err      <= w_err_nxt;
      locked     <= (w_state_nxt == S_LOCK);
      fault      <= (w_state_nxt == S_FAULT);
    end
  end

  assign err_vec = r_err;

endmodule

// File: tb/tb_monitor_relojes.sv
// Bench for monitor_relojes: a clock-chain generator drives the three divided clocks;
// expected period_f values are queued per generated f edge and compared after sync latency.
`timescale 1ns/1ps
module tb_monitor_relojes;
  localparam int CW = 16;

  logic          clk_in   = 1'b0;
  logic          reset_L  = 1'b0;
  logic          clk_4f_s = 1'b0;
  logic          clk_2f_s = 1'b0;
  logic          clk_f_s  = 1'b0;
  logic          clr      = 1'b0;
  logic          locked;
  logic          fault;
  logic [2:0]    err_vec;
  logic [CW-1:0] period_f;

  monitor_relojes #(.PER_4F(6), .TOL(1), .LOCK_N(4), .CW(CW)) dut (
    .clk_in  (clk_in),
    .reset_L (reset_L),
    .clk_4f_s(clk_4f_s),
    .clk_2f_s(clk_2f_s),
    .clk_f_s (clk_f_s),
    .clr     (clr),
    .locked  (locked),
    .fault   (fault),
    .err_vec (err_vec),
    .period_f(period_f)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {int exp; int due;} sb_t;
  sb_t sb_q[$];
  sb_t sb_e;
  int  total = 0, bad = 0;
  int  ncyc = 0, fcnt = 0, last2 = 0, prev_per = 0;
  int  ph[3];
  int  cur[3];
  bit  hold[3];
  bit  stretch4 = 0, alt_mode = 0, alt4 = 0, altf = 0, skip_f = 1;
  event ev_f, ev_2, ev_4;

  function automatic int nominal(input int c);
    return (c == 0) ? 24 : (c == 1) ? 12 : 6;
  endfunction

  // Generator (index 0=f, 1=2f, 2=4f) plus scoreboard drain, all on the falling edge
  always @(negedge clk_in) begin
    ncyc++;
    if (!reset_L) begin
      sb_q.delete();
      skip_f = 1; fcnt = 0; stretch4 = 0; alt4 = 0; altf = 0;
      for (int c = 0; c < 3; c++) begin
        cur[c] = nominal(c);
        ph[c]  = cur[c] - 1;
      end
      clk_f_s = 1'b0; clk_2f_s = 1'b0; clk_4f_s = 1'b0;
    end else begin
      while (sb_q.size() > 0 && sb_q[0].due <= ncyc) begin
        sb_e = sb_q.pop_front();
        total++;
        if (period_f !== CW'(sb_e.exp)) begin
          bad++;
          $display("FAIL sb_period_f: got %0d want %0d (cycle %0d)", period_f, sb_e.exp, ncyc);
        end
      end
      for (int c = 0; c < 3; c++) begin
        if (ph[c] >= cur[c] - 1) begin
          prev_per = cur[c];
          ph[c] = 0;
          if (c == 0) begin
            if (alt_mode) begin altf = ~altf; cur[c] = altf ? 23 : 25; end
            else cur[c] = 24;
          end else if (c == 1) begin
            cur[c] = 12;
          end else begin
            if (stretch4) begin cur[c] = 8; stretch4 = 0; end
            else if (alt_mode) begin alt4 = ~alt4; cur[c] = alt4 ? 5 : 7; end
            else cur[c] = 6;
          end
          if (!hold[c]) begin
            if (c == 0) begin
              fcnt++;
              if (skip_f) skip_f = 0;
              else sb_q.push_back('{exp: prev_per, due: ncyc + 4});
              ->ev_f;
            end else if (c == 1) begin
              last2 = ncyc;
              ->ev_2;
            end else begin
              ->ev_4;
            end
          end
        end else begin
          ph[c]++;
        end
      end
      clk_f_s  = (ph[0] < cur[0] / 2) && !hold[0];
      clk_2f_s = (ph[1] < cur[1] / 2) && !hold[1];
      clk_4f_s = (ph[2] < cur[2] / 2) && !hold[2];
    end
  end

  task automatic apply_reset();
    @(posedge clk_in); #3 reset_L = 1'b0;
    repeat (3) @(posedge clk_in);
    #3 reset_L = 1'b1;
  endtask

  task automatic wait_lock(input int maxc, output bit got);
    got = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_in); #1;
      if (locked) begin got = 1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_in);
    #2;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %0b want 0", locked); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %0b want 0", fault); end
    total++; if (err_vec !== 3'b000) begin bad++; $display("FAIL reset_err_vec: got %b want 000", err_vec); end
    total++; if (period_f !== '0) begin bad++; $display("FAIL reset_period_f: got %0d want 0", period_f); end
    @(posedge clk_in); #3 reset_L = 1'b1;
  endtask

  task automatic test_nominal_lock();
    bit got;
    wait_lock(400, got);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL nominal_lock_timeout: locked=%0b want 1", locked); end
    total++; if (fcnt != 5) begin bad++; $display("FAIL nominal_lock_edge: f edges=%0d want 5", fcnt); end
    repeat (60) @(negedge clk_in); #1;
    total++; if (period_f !== CW'(24)) begin bad++; $display("FAIL nominal_period_f: got %0d want 24", period_f); end
    total++; if ({locked, fault, err_vec} !== 5'b10000) begin
      bad++; $display("FAIL nominal_status: got %b want 10000", {locked, fault, err_vec});
    end
  endtask

  task automatic test_stuck_2f();
    bit got;
    @(ev_2);
    hold[1] = 1'b1;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in); #1;
      if (fault) begin got = 1; break; end
    end
    total++; if (got !== 1'b1) begin bad++; $display("FAIL stuck2f_fault_timeout: fault=%0b want 1", fault); end
    total++; if (ncyc - last2 != 17) begin bad++; $display("FAIL stuck2f_delay: got %0d want 17", ncyc - last2); end
    total++; if ({locked, err_vec} !== 4'b0010) begin
      bad++; $display("FAIL stuck2f_status: got %b want 0010", {locked, err_vec});
    end
    stretch4 = 1;
    @(ev_4); @(ev_4);
    repeat (3) @(negedge clk_in); #1;
    total++; if ({fault, err_vec} !== 4'b1110) begin
      bad++; $display("FAIL fault_sticky_or: got %b want 1110", {fault, err_vec});
    end
  endtask

  task automatic test_clr_with_bad();
    bit got;
    int t0;
    hold[1] = 1'b0;
    repeat (40) @(negedge clk_in);
    stretch4 = 1;
    @(ev_4); @(ev_4);
    @(negedge clk_in); @(negedge clk_in);
    clr = 1'b1; sb_q.delete(); skip_f = 1;
    @(negedge clk_in);
    clr = 1'b0;
    #1;
    total++; if ({locked, fault, err_vec} !== 5'b00000) begin
      bad++; $display("FAIL clr_status: got %b want 00000", {locked, fault, err_vec});
    end
    t0 = ncyc;
    wait_lock(300, got);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL clr_relock_timeout: locked=%0b want 1", locked); end
    total++; if (ncyc - t0 < 90 || ncyc - t0 > 160) begin
      bad++; $display("FAIL clr_relock_time: got %0d want 90..160", ncyc - t0);
    end
    total++; if ({fault, err_vec} !== 4'b0000) begin
      bad++; $display("FAIL clr_relock_err: got %b want 0000", {fault, err_vec});
    end
  endtask

  task automatic test_async_reset();
    bit got;
    @(posedge clk_in); #3 reset_L = 1'b0;
    #1;
    total++; if ({locked, fault, err_vec} !== 5'b00000) begin
      bad++; $display("FAIL areset_status: got %b want 00000", {locked, fault, err_vec});
    end
    total++; if (period_f !== '0) begin bad++; $display("FAIL areset_period_f: got %0d want 0", period_f); end
    repeat (3) @(posedge clk_in);
    #3 reset_L = 1'b1;
    wait_lock(400, got);
    total++; if (got !== 1'b1 || fcnt != 5) begin
      bad++; $display("FAIL areset_relock: locked=%0b edges=%0d want 1/5", locked, fcnt);
    end
    repeat (60) @(negedge clk_in); #1;
    total++; if ({fault, err_vec, period_f} !== {4'b0000, CW'(24)}) begin
      bad++; $display("FAIL areset_final: fault/err=%b period_f=%0d want 0000/24", {fault, err_vec}, period_f);
    end
  endtask

  task automatic test_stretch_acq();
    bit got;
    apply_reset();
    for (int i = 0; i < 10 && fcnt < 2; i++) @(ev_f);
    stretch4 = 1;
    wait_lock(400, got);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL stretch_lock_timeout: locked=%0b want 1", locked); end
    total++; if (fcnt != 6) begin bad++; $display("FAIL stretch_lock_edge: f edges=%0d want 6", fcnt); end
    total++; if ({fault, err_vec} !== 4'b0000) begin
      bad++; $display("FAIL stretch_err: got %b want 0000", {fault, err_vec});
    end
  endtask

  task automatic test_tolerance();
    bit got;
    alt_mode = 1;
    apply_reset();
    wait_lock(400, got);
    total++; if (got !== 1'b1 || fcnt != 5) begin
      bad++; $display("FAIL tol_lock: locked=%0b edges=%0d want 1/5", locked, fcnt);
    end
    repeat (80) @(negedge clk_in); #1;
    total++; if ({locked, fault, err_vec} !== 5'b10000) begin
      bad++; $display("FAIL tol_status: got %b want 10000", {locked, fault, err_vec});
    end
    alt_mode = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal_lock();
    test_stuck_2f();
    test_clr_with_bad();
    test_async_reset();
    test_stretch_acq();
    test_tolerance();
    repeat (5) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
